// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory-port arbiter: FSM states and owner encoding.
// Pure declarations; no timing or flow-control behaviour.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of lost fetch arbitrations; at_max forces the next fetch win.
// Updates one cycle after inc/clr; clr has priority; no backpressure.
module starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch vs data onto one memory port: gnt 1 cycle after request, rvalid MEM_LAT later.
// One access per MEM_LAT+2 cycles; data has priority, the loser holds req until it wins.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  arb_state_t        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              owner_q;

  logic arb;
  logic at_max;
  logic d_win;
  logic if_win;

  // Data wins ties unless fetch has already lost MAX_WAIT times in a row.
  assign arb    = (state == IDLE) && (if_req || d_req);
  assign d_win  = d_req && !(if_req && at_max);
  assign if_win = if_req && !d_win;

  starve_counter #(.MAX(MAX_WAIT)) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (arb && if_req && d_win),
    .clr    (arb && if_win),
    .at_max (at_max)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      owner_q  <= OWNER_IF;
    end else begin
      case (state)
        IDLE: begin
          if (arb) begin
            owner_q <= d_win ? OWNER_D : OWNER_IF;
            addr_q  <= d_win ? d_addr : if_addr;
            we_q    <= d_win && d_we;
            wdata_q <= d_win ? d_wdata : '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= CNT_W'(MEM_LAT - 1);
          state    <= (MEM_LAT > 1) ? WAIT : RESP;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == CNT_W'(1)) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign owner     = owner_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en && we_q;
  assign if_gnt    = mem_en && (owner_q == OWNER_IF);
  assign d_gnt     = mem_en && (owner_q == OWNER_D);
  assign if_rvalid = (state == RESP) && (owner_q == OWNER_IF);
  assign d_rvalid  = (state == RESP) && (owner_q == OWNER_D);
  // A completed store reports rvalid with zero data.
  assign if_rdata  = if_rvalid ? mem_rdata[31:0] : '0;
  assign d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2, MAX_WAIT=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [63:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        busy, owner;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(64), .MEM_LAT(2), .MAX_WAIT(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_busy",   64'(busy),     64'd0);
    check("rst_mem_en", 64'(mem_en),   64'd0);
    check("rst_addr",   64'(mem_addr), 64'd0);
    check("rst_owner",  64'(owner),    64'd0);
    reset = 1'b0;
    tick();

    // Fetch only
    if_req = 1'b1; if_addr = 32'h100; mem_rdata = 64'hAAAA_BBBB_1234_5678;
    tick();
    check("f_gnt",    64'(if_gnt),   64'd1);
    check("f_mem_en", 64'(mem_en),   64'd1);
    check("f_mem_we", 64'(mem_we),   64'd0);
    check("f_addr",   64'(mem_addr), 64'h100);
    check("f_dgnt",   64'(d_gnt),    64'd0);
    if_req = 1'b0;
    tick();
    check("f_c2_en",  64'(mem_en),    64'd0);
    check("f_c2_rv",  64'(if_rvalid), 64'd0);
    tick();
    check("f_rvalid", 64'(if_rvalid), 64'd1);
    check("f_rdata",  64'(if_rdata),  64'h1234_5678);
    check("f_drv",    64'(d_rvalid),  64'd0);
    tick();
    check("f_idle",   64'(busy),      64'd0);
    check("f_rdata0", 64'(if_rdata),  64'd0);

    // Store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 64'hDEAD;
    tick();
    check("s_gnt",   64'(d_gnt),     64'd1);
    check("s_en",    64'(mem_en),    64'd1);
    check("s_we",    64'(mem_we),    64'd1);
    check("s_wdata", mem_wdata,      64'hDEAD);
    check("s_addr",  64'(mem_addr),  64'h40);
    check("s_owner", 64'(owner),     64'd1);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check("s_c2_we", 64'(mem_we),    64'd0);
    tick();
    check("s_rvalid", 64'(d_rvalid), 64'd1);
    check("s_rdata",  d_rdata,       64'd0);
    tick();

    // Collision: data first, fetch after
    if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_addr = 32'h80;
    tick();
    check("c_dgnt",  64'(d_gnt),    64'd1);
    check("c_ifgnt", 64'(if_gnt),   64'd0);
    check("c_addr1", 64'(mem_addr), 64'h80);
    d_req = 1'b0;
    tick();
    check("c_addr2", 64'(mem_addr), 64'h80);
    tick();
    check("c_drv",   64'(d_rvalid),  64'd1);
    check("c_dat",   d_rdata,        64'hAAAA_BBBB_1234_5678);
    check("c_ifrv",  64'(if_rvalid), 64'd0);
    tick();
    check("c_addr4", 64'(mem_addr), 64'h80);
    tick();
    check("c_ifgnt5", 64'(if_gnt),   64'd1);
    check("c_addr5",  64'(mem_addr), 64'h200);
    if_req = 1'b0;
    tick(); tick();
    check("c_ifrv8", 64'(if_rvalid), 64'd1);
    tick();

    // Starvation: data wins four times, then fetch is forced through
    if_req = 1'b1; if_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      d_req = 1'b1; d_addr = 32'h10 + 32'(i);
      tick();
      check($sformatf("st_dgnt%0d", i),  64'(d_gnt),  64'd1);
      check($sformatf("st_ifgnt%0d", i), 64'(if_gnt), 64'd0);
      d_req = 1'b0;
      tick(); tick(); tick();
    end
    d_req = 1'b1;
    tick();
    check("st_force_if", 64'(if_gnt),   64'd1);
    check("st_force_d",  64'(d_gnt),    64'd0);
    check("st_addr",     64'(mem_addr), 64'h300);
    if_req = 1'b0;
    tick(); tick(); tick();
    if_req = 1'b1;
    tick();
    check("st_reset_d", 64'(d_gnt), 64'd1);
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick(); tick();

    // Reset during WAIT aborts the access
    if_req = 1'b1; if_addr = 32'h500;
    tick();
    if_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("r_busy",  64'(busy),      64'd0);
    check("r_addr",  64'(mem_addr),  64'd0);
    check("r_rv",    64'(if_rvalid), 64'd0);
    check("r_owner", 64'(owner),     64'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("r_norv%0d", i), 64'({if_rvalid, d_rvalid, busy}), 64'd0);
    end

    // Back-to-back fetch
    if_req = 1'b1; if_addr = 32'h600;
    for (int c = 1; c <= 16; c++) begin
      tick();
      check($sformatf("bb_gnt%0d", c), 64'(if_gnt),    64'(c % 4 == 1));
      check($sformatf("bb_rv%0d", c),  64'(if_rvalid), 64'(c % 4 == 3));
    end
    if_req = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
